// File: rtl/hood_pkg.sv
// Shared constants for the range-hood key front-end: key indices, speed one-hot codes,
// default timing and a small popcount helper used by the conflict arbitration.
package hood_pkg;

  localparam int NUM_KEYS = 5;
  localparam int K_MENU   = 0;
  localparam int K_SPD1   = 1;
  localparam int K_SPD2   = 2;
  localparam int K_SPD3   = 3;
  localparam int K_CLEAN  = 4;

  localparam logic [2:0] SPD_NONE = 3'b000;
  localparam logic [2:0] SPD_1    = 3'b001;
  localparam logic [2:0] SPD_2    = 3'b010;
  localparam logic [2:0] SPD_3    = 3'b100;

  // 10 ms debounce and 2 s long press at 100 MHz
  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 200_000_000;

  function automatic logic [1:0] count3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, mismatch-run counter that flips the stable level after
// DEBOUNCE_CYCLES consecutive mismatches, and a combinational rising-edge press strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          s;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a   <= 1'b0;
      s        <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_a   <= key;
      s        <= sync_a;
      stable_q <= stable;
      // any return to the stable level restarts the run from zero
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/hood_key_conditioner.sv
// Debounced, conflict-checked key events for the hood mode controller; all outputs registered,
// pulses appear DEBOUNCE_CYCLES+3 edges after the first sample of a new raw level.
module hood_key_conditioner
  import hood_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_menu,
  input  logic [2:0] key_spd,
  input  logic       key_clean,
  output logic       menu_btn,
  output logic       menu_long,
  output logic [2:0] speed_btn,
  output logic       clean_btn,
  output logic       key_conflict,
  output logic [4:0] key_stable
);

  localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_PRESS_CYCLES);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press;
  logic [LW-1:0]       lcnt;

  assign raw = {key_clean, key_spd, key_menu};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .reset  (reset),
      .key    (raw[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

  logic [2:0] spd_ev;
  logic [2:0] spd_lvl;
  logic       clean_ev;
  logic       spd_ok;
  logic       clean_ok;
  logic       spd_rej;
  logic       clean_rej;

  always_comb begin
    spd_ev    = press[K_SPD3:K_SPD1];
    spd_lvl   = stable[K_SPD3:K_SPD1];
    clean_ev  = press[K_CLEAN];
    // a gear change is only legal when it is the sole speed key down and clean is not racing it
    spd_ok    = (count3(spd_ev) == 2'd1) && (count3(spd_lvl) == 2'd1) && !clean_ev;
    clean_ok  = clean_ev && !(|spd_lvl) && !(|spd_ev);
    spd_rej   = (|spd_ev) && !spd_ok;
    clean_rej = clean_ev && !clean_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      menu_btn     <= 1'b0;
      menu_long    <= 1'b0;
      speed_btn    <= SPD_NONE;
      clean_btn    <= 1'b0;
      key_conflict <= 1'b0;
      lcnt         <= '0;
    end else begin
      menu_btn     <= press[K_MENU];
      speed_btn    <= spd_ok ? spd_ev : SPD_NONE;
      clean_btn    <= clean_ok;
      key_conflict <= spd_rej | clean_rej;
      menu_long    <= stable[K_MENU] && (lcnt == LONG_LAST);
      // saturating one past the fire point keeps menu_long to a single pulse per hold
      if (!stable[K_MENU]) begin
        lcnt <= '0;
      end else if (lcnt != LONG_SAT) begin
        lcnt <= lcnt + LW'(1);
      end
    end
  end

  assign key_stable = stable;

endmodule

// File: tb/tb_hood_key_conditioner.sv
// Scoreboarded bench for hood_key_conditioner with short debounce/long-press timing.
module tb_hood_key_conditioner;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int LAT = DB + 3;

  localparam logic [6:0] E_MENU  = 7'b1000000;
  localparam logic [6:0] E_LONG  = 7'b0100000;
  localparam logic [6:0] E_SPD1  = 7'b0000100;
  localparam logic [6:0] E_SPD2  = 7'b0001000;
  localparam logic [6:0] E_CLEAN = 7'b0000010;
  localparam logic [6:0] E_CONF  = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_menu;
  logic [2:0] key_spd;
  logic       key_clean;
  logic       menu_btn;
  logic       menu_long;
  logic [2:0] speed_btn;
  logic       clean_btn;
  logic       key_conflict;
  logic [4:0] key_stable;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [6:0] v;
  } exp_t;
  exp_t sb[$];

  hood_key_conditioner #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_menu     (key_menu),
    .key_spd      (key_spd),
    .key_clean    (key_clean),
    .menu_btn     (menu_btn),
    .menu_long    (menu_long),
    .speed_btn    (speed_btn),
    .clean_btn    (clean_btn),
    .key_conflict (key_conflict),
    .key_stable   (key_stable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // every nonzero output word must match the oldest expected event, in value and cycle
  always @(negedge clk) begin
    logic [6:0] obs;
    exp_t e;
    obs = {menu_btn, menu_long, speed_btn, clean_btn, key_conflict};
    if (obs !== 7'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d got=%b required=none", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e.v || cyc !== e.at) begin
          failures++;
          $display("FAIL event cyc=%0d got=%b required=%b at cyc=%0d", cyc, obs, e.v, e.at);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input int delay, input logic [6:0] v);
    exp_t e;
    e.at = cyc + delay;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic test_drained(input string name);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL %s_missing_events got=%0d pending required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; key_menu = 1'b0; key_spd = 3'b000; key_clean = 1'b0;
    wait_cycles(3);
    checks++;
    if ({menu_btn, menu_long, speed_btn, clean_btn, key_conflict, key_stable} !== 12'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0",
               {menu_btn, menu_long, speed_btn, clean_btn, key_conflict, key_stable});
    end
    reset = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_speed_single;
    key_spd = 3'b001;
    expect_event(LAT, E_SPD1);
    wait_cycles(9);
    checks++;
    if (key_stable !== 5'b00010) begin
      failures++;
      $display("FAIL spd1_stable got=%b required=00010", key_stable);
    end
    wait_cycles(1);
    key_spd = 3'b000;
    wait_cycles(12);
    test_drained("speed_single");
  endtask

  task automatic test_menu_glitch;
    logic seen;
    seen = 1'b0;
    key_menu = 1'b1;
    wait_cycles(DB - 1);
    key_menu = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_cycles(1);
      if (key_stable[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_stable got=%b required=0", seen);
    end
    test_drained("menu_glitch");
  endtask

  task automatic test_menu_long;
    key_menu = 1'b1;
    expect_event(LAT, E_MENU);
    expect_event(LAT + LP - 1, E_LONG);
    wait_cycles(30);
    key_menu = 1'b0;
    wait_cycles(12);
    test_drained("menu_long");
  endtask

  task automatic test_speed_double;
    key_spd = 3'b101;
    expect_event(LAT, E_CONF);
    wait_cycles(10);
    key_spd = 3'b000;
    wait_cycles(12);
    test_drained("speed_double");
  endtask

  task automatic test_speed_while_held;
    key_spd = 3'b001;
    expect_event(LAT, E_SPD1);
    wait_cycles(10);
    key_spd = 3'b011;
    expect_event(LAT, E_CONF);
    wait_cycles(10);
    key_spd = 3'b000;
    wait_cycles(12);
    test_drained("speed_while_held");
  endtask

  task automatic test_clean_vs_speed;
    key_spd = 3'b010;
    expect_event(LAT, E_SPD2);
    wait_cycles(10);
    key_clean = 1'b1;
    expect_event(LAT, E_CONF);
    wait_cycles(10);
    key_clean = 1'b0;
    key_spd = 3'b000;
    wait_cycles(12);
    key_clean = 1'b1;
    expect_event(LAT, E_CLEAN);
    wait_cycles(10);
    key_clean = 1'b0;
    wait_cycles(12);
    test_drained("clean_vs_speed");
  endtask

  task automatic test_clean_speed_same;
    key_spd = 3'b100;
    key_clean = 1'b1;
    expect_event(LAT, E_CONF);
    wait_cycles(10);
    key_spd = 3'b000;
    key_clean = 1'b0;
    wait_cycles(12);
    test_drained("clean_speed_same");
  endtask

  task automatic test_reset_mid_debounce;
    key_menu = 1'b1;
    wait_cycles(4);
    reset = 1'b0;
    #1;
    checks++;
    if ({menu_btn, menu_long, speed_btn, clean_btn, key_conflict, key_stable} !== 12'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b required=0",
               {menu_btn, menu_long, speed_btn, clean_btn, key_conflict, key_stable});
    end
    wait_cycles(3);
    reset = 1'b1;
    expect_event(LAT, E_MENU);
    wait_cycles(10);
    key_menu = 1'b0;
    wait_cycles(14);
    test_drained("reset_mid_debounce");
  endtask

  initial begin
    test_reset();
    test_speed_single();
    test_menu_glitch();
    test_menu_long();
    test_speed_double();
    test_speed_while_held();
    test_clean_vs_speed();
    test_clean_speed_same();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
